// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state type and frame constants for the instruction memory loader.
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR} state_t;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, control/status and memory write port of the loader.
interface imem_loader_if #(parameter int ADDR_W = 64);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  modport master (output start, byte_valid, byte_data,
                  input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
  modport slave  (input  start, byte_valid, byte_data,
                  output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
endinterface

// File: rtl/byte_stream_checksum.sv
// byte_stream_checksum: running XOR of accepted bytes with synchronous clear and enable.
module byte_stream_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);
  logic [7:0] acc_q, acc_d;
  always_comb acc_d = clr ? 8'h00 : en ? acc_q ^ din : acc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) acc_q <= 8'h00;
    else acc_q <= acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length/data/checksum byte frame and writes the payload into instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 16,
  parameter int ADDR_W    = 64
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);
  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d, mem_wdata_q, mem_wdata_d, chk;
  logic [15:0]       n_q, n_d, n_new;
  logic [17:0]       cnt_q, cnt_d, len4;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              byte_ready_q, byte_ready_d, cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d, error_q, error_d, mem_we_q, mem_we_d;
  logic              take, clr, en, oversize;

  byte_stream_checksum u_chk (.clk, .reset, .clr, .en, .din(bus.byte_data), .acc(chk));

  assign take     = bus.byte_valid && byte_ready_q;
  assign n_new    = {bus.byte_data, len_lo_q};
  // byte count kept at 18 bits so 4*N cannot alias below MEM_BYTES
  assign len4     = {n_new, 2'b00};
  assign oversize = len4 > 18'(MEM_BYTES);

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    clr         = 1'b0;
    en          = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: if (bus.start) begin
        state_d = LEN_LO;
        done_d  = 1'b0;
        error_d = 1'b0;
        cnt_d   = '0;
        clr     = 1'b1;
      end
      LEN_LO: if (take) begin
        len_lo_d = bus.byte_data;
        state_d  = LEN_HI;
      end
      LEN_HI: if (take) begin
        n_d     = n_new;
        error_d = oversize;
        state_d = oversize ? ERROR : (n_new == 16'd0) ? CHECK : DATA;
      end
      DATA: if (take) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = ADDR_W'(cnt_q);
        mem_wdata_d = bus.byte_data;
        en          = 1'b1;
        cnt_d       = cnt_q + 18'd1;
        state_d     = (cnt_q == {n_q, 2'b00} - 18'd1) ? CHECK : DATA;
      end
      CHECK: if (take) begin
        done_d  = bus.byte_data == chk;
        error_d = bus.byte_data != chk;
        state_d = (bus.byte_data == chk) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
    byte_ready_d = state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
    cpu_hold_d   = byte_ready_d;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      byte_ready_q <= 1'b0;
      cpu_hold_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      error_q      <= error_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      byte_ready_q <= byte_ready_d;
      cpu_hold_q   <= cpu_hold_d;
    end

  assign bus.byte_ready = byte_ready_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames checked against a frame-level model of the loader.
module tb_imem_loader;
  import imem_loader_pkg::*;
  localparam int MEM_BYTES = 16;
  localparam int ADDR_W    = 64;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();
  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_addr[$];
  logic [7:0] exp_data[$];
  logic exp_done, exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // frame-level model: expected writes and final status from the frame bytes alone
  task automatic model_frame(input bq_t f);
    int n;
    logic [7:0] x;
    n = int'({f[1], f[0]});
    x = 8'h00;
    if (4 * n > MEM_BYTES) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end else begin
      for (int k = 0; k < 4 * n; k++) begin
        exp_addr.push_back(k);
        exp_data.push_back(f[HDR_BYTES + k]);
        x ^= f[HDR_BYTES + k];
      end
      exp_done = f[HDR_BYTES + 4 * n] == x;
      exp_err  = !exp_done;
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (bus.mem_we) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.mem_addr, bus.mem_wdata);
      end else begin
        chk("wr_addr", bus.mem_addr, 64'(exp_addr.pop_front()));
        chk("wr_data", 64'(bus.mem_wdata), 64'(exp_data.pop_front()));
      end
    end
    chk("done_and_error", 64'(bus.done & bus.error), 64'd0);
  end

  task automatic send_bytes(input bq_t f, input bit thr, input bit poke, output bit ok);
    bit rdy;
    int t;
    ok = 1'b1;
    for (int i = 0; i < f.size(); i++) begin
      if (thr) repeat ($urandom_range(0, 2)) begin
        bus.byte_valid = 1'b0;
        bus.start = poke && i > 0 && $urandom_range(0, 2) == 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = f[i];
      t = 0;
      do begin
        rdy = bus.byte_ready;
        @(posedge clk); #1;
        t++;
      end while (!rdy && t < 100);
      bus.byte_valid = 1'b0;
      if (!rdy) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0d never accepted, ready=%0b required 1", i, bus.byte_ready);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ready_after_start", 64'(bus.byte_ready), 64'd1);
    chk("hold_after_start", 64'(bus.cpu_hold), 64'd1);
    chk("done_cleared", 64'(bus.done), 64'd0);
    chk("error_cleared", 64'(bus.error), 64'd0);
  endtask

  task automatic do_load(input bq_t f, input bit thr, input bit poke);
    bit ok;
    model_frame(f);
    pulse_start();
    send_bytes(f, thr, poke, ok);
    chk("final_done", 64'(bus.done), 64'(exp_done));
    chk("final_error", 64'(bus.error), 64'(exp_err));
    chk("final_hold", 64'(bus.cpu_hold), 64'd0);
    chk("final_ready", 64'(bus.byte_ready), 64'd0);
    chk("writes_left", 64'(exp_addr.size()), 64'd0);
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
    chk({tag, "_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, "_hold"}, 64'(bus.cpu_hold), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_error"}, 64'(bus.error), 64'd0);
    chk({tag, "_addr"}, bus.mem_addr, 64'd0);
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
  endtask

  initial begin
    bq_t f1, fb, f, part;
    bit ok;
    int n;
    logic [7:0] x, b;
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    f1 = '{8'h03, 8'h00, 8'hB3, 8'h09, 8'h10, 8'h00, 8'h33, 8'h86, 8'h39, 8'h40,
           8'hB3, 8'h86, 8'hC2, 8'h00, 8'h91};
    #1;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("post_reset");

    model_frame(f1);
    chk("model_f1_writes", 64'(exp_addr.size()), 64'd12);
    chk("model_f1_addr11", 64'(exp_addr[11]), 64'd11);
    chk("model_f1_data4", 64'(exp_data[4]), 64'h33);
    chk("model_f1_done", 64'(exp_done), 64'd1);
    exp_addr.delete();
    exp_data.delete();
    do_load(f1, 1'b0, 1'b0);

    fb = f1;
    fb[14] = 8'h90;
    model_frame(fb);
    chk("model_bad_err", 64'(exp_err), 64'd1);
    exp_addr.delete();
    exp_data.delete();
    do_load(fb, 1'b0, 1'b0);

    do_load('{8'h05, 8'h00}, 1'b0, 1'b0);
    chk("oversize_error", 64'(bus.error), 64'd1);
    do_load('{8'h01, 8'h40}, 1'b0, 1'b0);
    chk("oversize_wide_error", 64'(bus.error), 64'd1);
    do_load('{8'h00, 8'h00, 8'h00}, 1'b0, 1'b0);
    chk("zero_len_done", 64'(bus.done), 64'd1);
    do_load('{8'h00, 8'h00, 8'h01}, 1'b0, 1'b0);
    chk("zero_len_error", 64'(bus.error), 64'd1);
    do_load('{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h10}, 1'b0, 1'b0);
    chk("full_mem_done", 64'(bus.done), 64'd1);
    do_load(f1, 1'b1, 1'b1);
    chk("throttled_done", 64'(bus.done), 64'd1);

    model_frame(f1);
    pulse_start();
    part = f1[0:6];
    send_bytes(part, 1'b0, 1'b0, ok);
    chk("mid_reset_we_pending", 64'(bus.mem_we), 64'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("after_abort");
    do_load(f1, 1'b0, 1'b0);
    chk("reload_done", 64'(bus.done), 64'd1);

    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(0, 5);
      f = '{};
      f.push_back(8'(n));
      f.push_back(8'h00);
      if (n <= 4) begin
        x = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
          b = 8'($urandom);
          f.push_back(b);
          x ^= b;
        end
        f.push_back(($urandom_range(0, 3) == 0) ? x ^ 8'($urandom_range(1, 255)) : x);
      end
      do_load(f, 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end
endmodule
